ed25519_point_add_seq: RTL and testbench
========================================

Name: ed25519_point_add_seq

Overview:
- Sequential responder for the point-addition start/done handshake used by the ed25519 scalar-multiply controller.
- Computes the twisted-Edwards extended-coordinate sum P3 = P1 + P2 over GF(q), q = 2^255 - 19, using the RFC 8032 unified add formula. The same formula also performs doubling when P1 = P2.
- Uses one shared bit-serial modular multiplier, sequenced by an FSM.
- Drop-in for the controller's adder instance; port names and widths match.

Parameters:
- W, 255, field width in bits and number of iterations per modular multiply.
- PW, 257, port width of each coordinate (the codebase's `b).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- x1,y1,z1,t1  in  PW  operand P1; bits PW-1:W ignored
- x2,y2,z2,t2  in  PW  operand P2; bits PW-1:W ignored
- done  out  1  one-cycle pulse; x3..t3 are valid from this cycle onward
- x3,y3,z3,t3  out  PW  result; bits PW-1:W always 0

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE, done = 0, x3..t3 = 0, all internal registers = 0.
  - Reset asserted mid-operation aborts the operation; no done pulse follows.
- Operand capture: in IDLE with start=1, all eight operands are latched (low W bits) and the FSM moves to PRE. Inputs are not sampled again during the operation.
- start in any state other than IDLE is ignored.
- PRE (1 cycle): compute s1=y1-x1, s2=y2-x2, a1=y1+x1, a2=y2+x2, all mod q.
- MUL (operations 0..4, then MID, then 5..8). Each multiply takes W+1 cycles:
  - 1 load cycle.
  - W MSB-first interleaved iterations: acc = 2·acc mod q, then acc = acc + a mod q if bit(b) is set.
  - Each reduction is a single conditional subtract of q.
- Operation schedule:
  - op0: A = s1·s2
  - op1: B = a1·a2
  - op2: C' = t1·t2
  - op3: C = C'·K2D, where K2D = 2d mod q = 16295367250680780974490674513165176452449235426866156013048779062215315747161
  - op4: D' = z1·z2
- MID (1 cycle): D = 2D' mod q; E = B-A; F = D-C; G = D+C; H = B+A, all mod q.
- Remaining operations:
  - op5: X = E·F
  - op6: Y = G·H
  - op7: T = E·H
  - op8: Z = F·G
  - On the final op8 iteration edge: write x3..t3, drive done=1, go to IDLE.
- Latency: done goes high 9·(W+1)+2 clock edges after the edge that samples start. For W=255 this is 2306 cycles. The latency is fixed and independent of the data.
- done:
  - High for exactly 1 cycle, otherwise low.
  - Low in the cycle after start is accepted, so a controller that polls done immediately after pulsing start never sees a stale result.
- Outputs hold their last value until the next done pulse or reset.
- Modular add/sub: operands < q; a W+1-bit intermediate, followed by one conditional ±q correction, gives a result in [0,q).
- Back-to-back use: start is accepted in the cycle right after done (IDLE); there is no dead cycle.
- Inputs ≥ q (low W bits) without the optional feature: result undefined, no hang; done still pulses at the fixed latency.

Optional Feature:
- Macro: ED25519_PA_INPUT_REDUCE_EN.
- Defined: PRE lasts 2 cycles. The first cycle conditionally subtracts q from each of the eight latched coordinates; the second performs the sums and differences. Results are correct for any W-bit input. Latency becomes 9·(W+1)+3 (2307).
- Undefined: single-cycle PRE as above; inputs must be < q.

Test Plan:
- Identity + identity: (0,1,1,0)+(0,1,1,0), start pulse → after 2306 cycles done=1 for one cycle; x3=0, y3=4, z3=4, t3=0.
- Identity + base point:
  - Inputs: P2 = (Bx, By, 1, Bx·By mod q), with Bx = 15112221349535400772501151409588531511454012693041857206046113283949847762202 and By = 46316835694926478169428394003475163141307993866256225615783033603165251855960.
  - Expected: x3 = 4Bx mod q, y3 = 4By mod q, z3 = 4, t3 = 4·Bx·By mod q.
- Doubling: P1 = P2 = base point → (x3/z3, y3/z3) equals the affine 2B from the software model; bits 256:255 of all outputs are 0.
- Handshake: start pulsed again at cycles 10 and 1000 of a busy operation → both ignored; exactly one done at cycle 2306. New start in the cycle after done → second done 2306 cycles later.
- Reset mid-op: rst_n low at cycle 1200 for 3 cycles → done=0 and x3..t3=0 immediately; no done pulse within 3000 cycles; a fresh start then completes normally.
- Feature on: P1 = (q, q+1, q+1, q), i.e. identity offset by q, plus identity → same as the first scenario; done at 2307.

Source files
------------

// File: rtl/ed25519_point_add_seq.sv
// Ed25519 extended-coordinate point adder (unified formula). It uses one bit-serial modular multiplier.
// Defining ED25519_PA_INPUT_REDUCE_EN adds a pre-pass that folds inputs >= q into [0,q).
module ed25519_point_add_seq #(
  parameter int W  = 255,
  parameter int PW = 257
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [PW-1:0] x1,
  input  logic [PW-1:0] y1,
  input  logic [PW-1:0] z1,
  input  logic [PW-1:0] t1,
  input  logic [PW-1:0] x2,
  input  logic [PW-1:0] y2,
  input  logic [PW-1:0] z2,
  input  logic [PW-1:0] t2,
  output logic          done,
  output logic [PW-1:0] x3,
  output logic [PW-1:0] y3,
  output logic [PW-1:0] z3,
  output logic [PW-1:0] t3
);

  localparam int            CW  = $clog2(W);
  localparam logic [W-1:0]  Q   = {W{1'b1}} - W'(18);
  localparam logic [W-1:0]  K2D =
    W'(256'h2406d9dc56dffce7198e80f2eef3d13000e0149a8283b156ebd69b9426b2f159);

  typedef enum logic [2:0] {S_IDLE, S_RED, S_PRE, S_LOAD, S_ITER, S_MID} state_t;

  // NOTE: blocking assignments are right inside functions and always_comb (temporaries);
  // registers are only ever written with <= in always_ff.
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[W]) d = d + {1'b0, Q};
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] fold_q(input logic [W-1:0] a);
    return (a >= Q) ? a - Q : a;
  endfunction

  state_t        state, state_d;
  logic [W-1:0]  x1r, y1r, z1r, t1r, x2r, y2r, z2r, t2r;
  logic [W-1:0]  s1, s2, a1, a2;
  // ra/rb/rc hold A/B/C first and are reused for X/Y/T once MID has consumed them.
  logic [W-1:0]  ra, rb, rc, rd;
  logic [W-1:0]  re, rf, rg, rh;
  logic [W-1:0]  acc, ma, mb;
  logic [W-1:0]  mul_a, mul_b, acc_dbl, acc_nxt, d_dbl;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    op;
  logic [W-1:0]  x3r, y3r, z3r, t3r;
  logic          last_iter;
  logic          unused_hi;

  assign unused_hi = ^{x1[PW-1:W], y1[PW-1:W], z1[PW-1:W], t1[PW-1:W],
                       x2[PW-1:W], y2[PW-1:W], z2[PW-1:W], t2[PW-1:W]};

  assign last_iter = (state == S_ITER) && (bit_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // NOTE: state_d gets its default before the case so that no path infers a latch.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef ED25519_PA_INPUT_REDUCE_EN
          state_d = S_RED;
`else
          state_d = S_PRE;
`endif
        end
      end
      S_RED:  state_d = S_PRE;
      S_PRE:  state_d = S_LOAD;
      S_LOAD: state_d = S_ITER;
      S_ITER: begin
        if (last_iter) begin
          if (op == 4'd4)      state_d = S_MID;
          else if (op == 4'd8) state_d = S_IDLE;
          else                 state_d = S_LOAD;
        end
      end
      S_MID:  state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (op)
      4'd0: begin mul_a = s1;  mul_b = s2;  end
      4'd1: begin mul_a = a1;  mul_b = a2;  end
      4'd2: begin mul_a = t1r; mul_b = t2r; end
      4'd3: begin mul_a = rc;  mul_b = K2D; end
      4'd4: begin mul_a = z1r; mul_b = z2r; end
      4'd5: begin mul_a = re;  mul_b = rf;  end
      4'd6: begin mul_a = rg;  mul_b = rh;  end
      4'd7: begin mul_a = re;  mul_b = rh;  end
      4'd8: begin mul_a = rf;  mul_b = rg;  end
      default: ;
    endcase
  end

  // One MSB-first double-and-add step of the interleaved multiplier.
  assign acc_dbl = mod_add(acc, acc);
  assign acc_nxt = mb[W-1] ? mod_add(acc_dbl, ma) : acc_dbl;
  assign d_dbl   = mod_add(rd, rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      x1r <= '0; y1r <= '0; z1r <= '0; t1r <= '0;
      x2r <= '0; y2r <= '0; z2r <= '0; t2r <= '0;
      s1  <= '0; s2  <= '0; a1  <= '0; a2  <= '0;
      ra  <= '0; rb  <= '0; rc  <= '0; rd  <= '0;
      re  <= '0; rf  <= '0; rg  <= '0; rh  <= '0;
      acc <= '0; ma  <= '0; mb  <= '0;
      bit_cnt <= '0;
      op      <= '0;
      x3r <= '0; y3r <= '0; z3r <= '0; t3r <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x1r <= x1[W-1:0]; y1r <= y1[W-1:0]; z1r <= z1[W-1:0]; t1r <= t1[W-1:0];
            x2r <= x2[W-1:0]; y2r <= y2[W-1:0]; z2r <= z2[W-1:0]; t2r <= t2[W-1:0];
            op  <= '0;
          end
        end
        S_RED: begin
          x1r <= fold_q(x1r); y1r <= fold_q(y1r); z1r <= fold_q(z1r); t1r <= fold_q(t1r);
          x2r <= fold_q(x2r); y2r <= fold_q(y2r); z2r <= fold_q(z2r); t2r <= fold_q(t2r);
        end
        S_PRE: begin
          s1 <= mod_sub(y1r, x1r);
          s2 <= mod_sub(y2r, x2r);
          a1 <= mod_add(y1r, x1r);
          a2 <= mod_add(y2r, x2r);
        end
        S_LOAD: begin
          acc     <= '0;
          ma      <= mul_a;
          mb      <= mul_b;
          bit_cnt <= CW'(W - 1);
        end
        S_ITER: begin
          acc     <= acc_nxt;
          mb      <= mb << 1;
          bit_cnt <= bit_cnt - CW'(1);
          if (bit_cnt == '0) begin
            op <= op + 4'd1;
            case (op)
              4'd0:       ra <= acc_nxt;
              4'd1:       rb <= acc_nxt;
              4'd2, 4'd3: rc <= acc_nxt;
              4'd4:       rd <= acc_nxt;
              4'd5:       ra <= acc_nxt;
              4'd6:       rb <= acc_nxt;
              4'd7:       rc <= acc_nxt;
              4'd8: begin
                x3r  <= ra;
                y3r  <= rb;
                t3r  <= rc;
                z3r  <= acc_nxt;
                done <= 1'b1;
                op   <= '0;
              end
              default: ;
            endcase
          end
        end
        S_MID: begin
          rd <= d_dbl;
          re <= mod_sub(rb, ra);
          rf <= mod_sub(d_dbl, rc);
          rg <= mod_add(d_dbl, rc);
          rh <= mod_add(rb, ra);
        end
        default: ;
      endcase
    end
  end

  assign x3 = {{(PW-W){1'b0}}, x3r};
  assign y3 = {{(PW-W){1'b0}}, y3r};
  assign z3 = {{(PW-W){1'b0}}, z3r};
  assign t3 = {{(PW-W){1'b0}}, t3r};

endmodule

// File: tb/tb_ed25519_point_add_seq.sv
// Bench for ed25519_point_add_seq. It has a field-arithmetic reference model and a per-cycle compare process.
// It also runs directed scenarios; the feature scenario runs only with ED25519_PA_INPUT_REDUCE_EN.
module tb_ed25519_point_add_seq;

  localparam int PW = 257;
`ifdef ED25519_PA_INPUT_REDUCE_EN
  localparam int LAT = 2307;
`else
  localparam int LAT = 2306;
`endif

  localparam logic [254:0] Q    = {255{1'b1}} - 255'd18;
  localparam logic [254:0] BX   =
    255'(256'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a);
  localparam logic [254:0] BY   =
    255'(256'h6666666666666666666666666666666666666666666666666666666666666658);
  localparam logic [254:0] DCON =
    255'(256'h52036cee2b6ffe738cc740797779e89800700a4d4141d8ab75eb4dca135978a3);
  localparam logic [254:0] K2D  =
    255'(256'h2406d9dc56dffce7198e80f2eef3d13000e0149a8283b156ebd69b9426b2f159);

  typedef struct packed {
    logic [254:0] x;
    logic [254:0] y;
    logic [254:0] z;
    logic [254:0] t;
  } pt_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] x1 = '0, y1 = '0, z1 = '0, t1 = '0;
  logic [PW-1:0] x2 = '0, y2 = '0, z2 = '0, t2 = '0;
  logic          done;
  logic [PW-1:0] x3, y3, z3, t3;

  int n_tests = 0;
  int n_fail  = 0;

  ed25519_point_add_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x1(x1), .y1(y1), .z1(z1), .t1(t1),
    .x2(x2), .y2(y2), .z2(z2), .t2(t2),
    .done(done), .x3(x3), .y3(y3), .z3(z3), .t3(t3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Field arithmetic over GF(2^255-19) by plain wide arithmetic.
  function automatic logic [254:0] fadd(input logic [254:0] a, input logic [254:0] b);
    logic [255:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, Q};
    return s[254:0];
  endfunction

  function automatic logic [254:0] fsub(input logic [254:0] a, input logic [254:0] b);
    logic [255:0] s;
    s = ({1'b0, a} + {1'b0, Q} - {1'b0, b}) % {1'b0, Q};
    return s[254:0];
  endfunction

  function automatic logic [254:0] fmul(input logic [254:0] a, input logic [254:0] b);
    logic [509:0] p;
    p = ({255'b0, a} * {255'b0, b}) % {255'b0, Q};
    return p[254:0];
  endfunction

  function automatic logic [254:0] finv(input logic [254:0] a);
    logic [254:0] r, e;
    r = 255'd1;
    e = Q - 255'd2;
    for (int i = 254; i >= 0; i--) begin
      r = fmul(r, r);
      if (e[i]) r = fmul(r, a);
    end
    return r;
  endfunction

  function automatic logic [254:0] fred(input logic [254:0] a);
    return a % Q;
  endfunction

  function automatic pt_t padd(input pt_t p, input pt_t r);
    logic [254:0] a, b, c, d, e, f, g, h;
    pt_t o;
    a = fmul(fsub(p.y, p.x), fsub(r.y, r.x));
    b = fmul(fadd(p.y, p.x), fadd(r.y, r.x));
    c = fmul(fmul(p.t, K2D), r.t);
    d = fadd(fmul(p.z, r.z), fmul(p.z, r.z));
    e = fsub(b, a); f = fsub(d, c); g = fadd(d, c); h = fadd(b, a);
    o.x = fmul(e, f); o.y = fmul(g, h); o.t = fmul(e, h); o.z = fmul(f, g);
    return o;
  endfunction

  // Transaction-level reference: a request seen while idle produces its sum LAT edges later.
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  int   m_cnt  = 0;
  pt_t  m_pend = '0;
  pt_t  m_out  = '0;

  always @(posedge clk or negedge rst_n) begin
    pt_t p, r;
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_pend = '0; m_out = '0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == LAT) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_out  = m_pend;
        end
      end else if (start) begin
        p.x = fred(x1[254:0]); p.y = fred(y1[254:0]); p.z = fred(z1[254:0]); p.t = fred(t1[254:0]);
        r.x = fred(x2[254:0]); r.y = fred(y2[254:0]); r.z = fred(z2[254:0]); r.t = fred(t2[254:0]);
        m_pend = padd(p, r);
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("done", {256'b0, done}, {256'b0, m_done});
    check("x3", x3, {2'b0, m_out.x});
    check("y3", y3, {2'b0, m_out.y});
    check("z3", z3, {2'b0, m_out.z});
    check("t3", t3, {2'b0, m_out.t});
  end

  task automatic set_pts(input pt_t p, input pt_t r);
    x1 = {2'b0, p.x}; y1 = {2'b0, p.y}; z1 = {2'b0, p.z}; t1 = {2'b0, p.t};
    x2 = {2'b0, r.x}; y2 = {2'b0, r.y}; z2 = {2'b0, r.z}; t2 = {2'b0, r.t};
  endtask

  // Call just after a falling edge; returns just after the falling edge that shows done.
  task automatic run_op(input bit inject, output int lat);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check("done_low_after_start", {256'b0, done}, '0);
    lat = 3001;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      #1;
      start = inject && (k == 10 || k == 1000);
      if (start) x1 = PW'({$urandom, $urandom, $urandom});
    end
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks failed", n_fail, n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    pt_t id, bp, fz;
    int lat, pulses;
    logic [254:0] xx, yy, k, ax, ay;

    id = '{x: 255'd0, y: 255'd1, z: 255'd1, t: 255'd0};
    bp = '{x: BX, y: BY, z: 255'd1, t: fmul(BX, BY)};

    repeat (3) @(negedge clk);
    check("reset_done", {256'b0, done}, '0);
    check("reset_y3", y3, '0);
    check("reset_z3", z3, '0);
    #1 rst_n = 1'b1;

    check("pin_add_wrap", {2'b0, fadd(Q - 255'd1, 255'd2)}, 257'd1);
    check("pin_mul_neg1", {2'b0, fmul(Q - 255'd1, Q - 255'd1)}, 257'd1);
    check("pin_k2d", {2'b0, fadd(DCON, DCON)}, {2'b0, K2D});
    check("pin_model_ident", {2'b0, padd(id, id).y}, 257'd4);

    // Identity + identity
    @(negedge clk); #1;
    set_pts(id, id);
    run_op(1'b0, lat);
    check("lat_ident", lat, LAT);
    check("ident_x3", x3, 257'd0);
    check("ident_y3", y3, 257'd4);
    check("ident_z3", z3, 257'd4);
    check("ident_t3", t3, 257'd0);

    // Identity + base point
    @(negedge clk); #1;
    set_pts(id, bp);
    run_op(1'b0, lat);
    check("lat_idb", lat, LAT);
    check("idb_x3", x3, {2'b0, fmul(255'd4, BX)});
    check("idb_y3", y3, {2'b0, fmul(255'd4, BY)});
    check("idb_z3", z3, 257'd4);
    check("idb_t3", t3, {2'b0, fmul(255'd4, fmul(BX, BY))});

    // Doubling, checked against the affine Edwards doubling of B
    @(negedge clk); #1;
    set_pts(bp, bp);
    run_op(1'b0, lat);
    check("lat_dbl", lat, LAT);
    xx = fmul(BX, BX);
    yy = fmul(BY, BY);
    k  = fmul(DCON, fmul(xx, yy));
    ax = fmul(fadd(fmul(BX, BY), fmul(BX, BY)), finv(fadd(255'd1, k)));
    ay = fmul(fadd(yy, xx), finv(fsub(255'd1, k)));
    check("dbl_affine_x", x3, {2'b0, fmul(ax, z3[254:0])});
    check("dbl_affine_y", y3, {2'b0, fmul(ay, z3[254:0])});
    check("dbl_t_consistent", {2'b0, fmul(t3[254:0], z3[254:0])}, {2'b0, fmul(x3[254:0], y3[254:0])});
    check("dbl_hi_bits", {249'b0, x3[256:255], y3[256:255], z3[256:255], t3[256:255]}, '0);

    // Stray starts while busy, then back-to-back start in the done cycle
    @(negedge clk); #1;
    set_pts(id, bp);
    run_op(1'b1, lat);
    check("lat_busy_starts", lat, LAT);
    check("busy_x3", x3, {2'b0, fmul(255'd4, BX)});
    set_pts(id, id);
    run_op(1'b0, lat);
    check("lat_back2back", lat, LAT);
    check("b2b_y3", y3, 257'd4);

    // Reset mid-operation
    @(negedge clk); #1;
    set_pts(bp, bp);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (1199) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_done", {256'b0, done}, '0);
    check("midrst_y3", y3, '0);
    check("midrst_z3", z3, '0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("no_done_after_reset", pulses, 0);
    #1;
    set_pts(id, bp);
    run_op(1'b0, lat);
    check("lat_after_reset", lat, LAT);
    check("after_reset_y3", y3, {2'b0, fmul(255'd4, BY)});

`ifdef ED25519_PA_INPUT_REDUCE_EN
    // Identity offset by q in every coordinate, plus identity
    @(negedge clk); #1;
    fz = '{x: Q, y: Q + 255'd1, z: Q + 255'd1, t: Q};
    set_pts(fz, id);
    run_op(1'b0, lat);
    check("lat_reduce", lat, 2307);
    check("reduce_x3", x3, 257'd0);
    check("reduce_y3", y3, 257'd4);
    check("reduce_z3", z3, 257'd4);
    check("reduce_t3", t3, 257'd0);
`else
    fz = id;
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
